// File: rtl/snow64_long_div_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | snow64_long_div_arb_pkg                                              |
// | Shared types and widths for the long-divider arbiter.                |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package snow64_long_div_arb_pkg;

  localparam int unsigned C_DIVIDEND_W      = 16;
  localparam int unsigned C_DIVISOR_W       = 8;
  localparam int unsigned C_QUOT_W          = 16;
  localparam int unsigned C_NUM_REQ_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_SYNC  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_BUSY  = 3'd3,
    ST_RESP  = 3'd4
  } LongDivArbState;

endpackage
`default_nettype wire

// File: rtl/snow64_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | snow64_rr_picker                                                     |
// | Combinational round-robin picker: first valid above last_grant,      |
// | wrapping to the lowest valid index.                                  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module snow64_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_valid
);

  logic            hi_hit;
  logic            lo_hit;
  logic [ID_W-1:0] hi_id;
  logic [ID_W-1:0] lo_id;

  // Two ascending searches: above last_grant first, then the wrapped part.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        if (i > int'(last_grant)) begin
          if (!hi_hit) begin
            hi_hit = 1'b1;
            hi_id  = ID_W'(i);
          end
        end else if (!lo_hit) begin
          lo_hit = 1'b1;
          lo_id  = ID_W'(i);
        end
      end
    end
    grant_id  = hi_hit ? hi_id : lo_id;
    any_valid = hi_hit | lo_hit;
    grant     = any_valid ? (NUM_REQ'(1) << grant_id) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/long_div_u16_by_u8_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | long_div_u16_by_u8_arbiter                                           |
// | Round-robin sequencer sharing one 16/8 divider among NUM_REQ users.  |
// | Option macro: SNOW64_LONG_DIV_ARB_DIV0_FLAG_EN adds rsp_div0.        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module long_div_u16_by_u8_arbiter
  import snow64_long_div_arb_pkg::*;
#(
  parameter int NUM_REQ = C_NUM_REQ_DEFAULT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*C_DIVIDEND_W-1:0]   req_a,
  input  logic [NUM_REQ*C_DIVISOR_W-1:0]    req_b,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
  output logic [C_QUOT_W-1:0]               rsp_quot,
`ifdef SNOW64_LONG_DIV_ARB_DIV0_FLAG_EN
  output logic                              rsp_div0,
`endif
  output logic                              div_start,
  output logic [C_DIVIDEND_W-1:0]           div_a,
  output logic [C_DIVISOR_W-1:0]            div_b,
  input  logic                              div_can_accept,
  input  logic                              div_data_valid,
  input  logic [C_QUOT_W-1:0]               div_data
);

  localparam int ID_W = $clog2(NUM_REQ);

  LongDivArbState            state_q, state_d;
  logic [ID_W-1:0]           last_grant_q, last_grant_d;
  logic [ID_W-1:0]           id_q, id_d;
  logic [C_DIVIDEND_W-1:0]   a_q, a_d;
  logic [C_DIVISOR_W-1:0]    b_q, b_d;
  logic                      start_q, start_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [C_QUOT_W-1:0]       quot_q, quot_d;
`ifdef SNOW64_LONG_DIV_ARB_DIV0_FLAG_EN
  logic                      div0_q, div0_d;
`endif

  logic [NUM_REQ-1:0]        pick_grant;
  logic [ID_W-1:0]           pick_id;
  logic                      pick_any;

  snow64_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .grant_id   (pick_id),
    .any_valid  (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    start_d      = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    quot_d       = quot_q;
`ifdef SNOW64_LONG_DIV_ARB_DIV0_FLAG_EN
    div0_d       = div0_q;
`endif
    req_ready    = '0;
    case (state_q)
      // The divider has no reset; wait until it is idle before using it.
      ST_SYNC: begin
        if (div_can_accept) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        req_ready = pick_grant;
        if (pick_any) begin
          a_d          = req_a[32'(pick_id)*C_DIVIDEND_W +: C_DIVIDEND_W];
          b_d          = req_b[32'(pick_id)*C_DIVISOR_W +: C_DIVISOR_W];
          id_d         = pick_id;
          last_grant_d = pick_id;
          start_d      = 1'b1;
          state_d      = ST_ISSUE;
        end
      end
      // Completion is not looked at here: data_valid may still be stale.
      ST_ISSUE: begin
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (div_data_valid && div_can_accept) begin
          quot_d      = div_data;
`ifdef SNOW64_LONG_DIV_ARB_DIV0_FLAG_EN
          div0_d      = (b_q == '0);
`endif
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_SYNC;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      start_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      quot_q       <= '0;
`ifdef SNOW64_LONG_DIV_ARB_DIV0_FLAG_EN
      div0_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      start_q      <= start_d;
      rsp_valid_q  <= rsp_valid_d;
      quot_q       <= quot_d;
`ifdef SNOW64_LONG_DIV_ARB_DIV0_FLAG_EN
      div0_q       <= div0_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_quot  = quot_q;
  assign div_start = start_q;
  assign div_a     = a_q;
  assign div_b     = b_q;
`ifdef SNOW64_LONG_DIV_ARB_DIV0_FLAG_EN
  assign rsp_div0  = div0_q;
`endif

endmodule
`default_nettype wire
